// File: rtl/s_interp_param.sv
// S-Machine multi-cycle interpreter: one instruction per start/done handshake,
// internal register file and flags, request/acknowledge data-memory port.
module s_interp_param #(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 8,
    parameter  int NREG   = 4,
    localparam int REG_W  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] PC,
    output logic              flag_z,
    output logic              flag_c,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [REG_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    localparam logic [3:0] OP_LDI = 4'h0, OP_LD  = 4'h1, OP_INC = 4'h2, OP_ST  = 4'h3,
                           OP_ADD = 4'h4, OP_SUB = 4'h5, OP_OR  = 4'h6, OP_AND = 4'h7,
                           OP_XOR = 4'h8, OP_DEC = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB,
                           OP_JC  = 4'hC, OP_MOV = 4'hD, OP_ILL = 4'hF;

    typedef enum logic [1:0] {IDLE, EXEC, MEM, DONE} state_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs;
        logic [ADDR_W-1:0] imm;
    } instr_t;

    state_t                       state, state_nxt;
    instr_t                       ir;
    logic [NREG-1:0][DATA_W-1:0]  regs;

    logic [DATA_W-1:0] a, b, alu_res;
    logic [DATA_W:0]   wide;
    logic              alu_c, wr_rd, upd_c, is_mem;
    logic [ADDR_W-1:0] pc_inc, pc_nxt;

    assign dbg_data = regs[dbg_sel];
    assign is_mem   = (ir.op == OP_LD) || (ir.op == OP_ST);
    assign pc_inc   = PC + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXEC;
            EXEC:    state_nxt = is_mem ? MEM : DONE;
            MEM:     if (mem_ack) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU and branch resolution for the latched instruction.
    always_comb begin
        a       = regs[ir.rd];
        b       = regs[ir.rs];
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        wr_rd   = 1'b0;
        upd_c   = 1'b0;
        pc_nxt  = pc_inc;
        case (ir.op)
            OP_LDI: begin alu_res = DATA_W'(ir.imm); wr_rd = 1'b1; end
            OP_MOV: begin alu_res = b; wr_rd = 1'b1; end
            OP_INC, OP_ADD: begin
                wide    = {1'b0, a} + ((ir.op == OP_INC) ? (DATA_W+1)'(1) : {1'b0, b});
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
                wr_rd   = 1'b1;
                upd_c   = 1'b1;
            end
            OP_SUB, OP_DEC: begin
                // top bit of the widened difference is the unsigned borrow
                wide    = {1'b0, a} - ((ir.op == OP_DEC) ? (DATA_W+1)'(1) : {1'b0, b});
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
                wr_rd   = 1'b1;
                upd_c   = 1'b1;
            end
            OP_OR:  begin alu_res = a | b; wr_rd = 1'b1; upd_c = 1'b1; end
            OP_AND: begin alu_res = a & b; wr_rd = 1'b1; upd_c = 1'b1; end
            OP_XOR: begin alu_res = a ^ b; wr_rd = 1'b1; upd_c = 1'b1; end
            OP_JMP: pc_nxt = ir.imm;
            OP_JZ:  if (flag_z) pc_nxt = ir.imm;
            OP_JC:  if (flag_c) pc_nxt = ir.imm;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir        <= '0;
            regs      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            PC        <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // status outputs track the state being entered so they stay registered
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
            err  <= (state_nxt == DONE) && (ir.op == OP_ILL);
            case (state)
                IDLE: if (start) ir <= instr_t'({inst[DATA_W-1 -: 4 + 2*REG_W], inst[ADDR_W-1:0]});
                EXEC: begin
                    if (is_mem) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (ir.op == OP_ST);
                        mem_addr  <= ir.imm;
                        mem_wdata <= a;
                    end else begin
                        if (wr_rd) begin
                            regs[ir.rd] <= alu_res;
                            flag_z      <= (alu_res == '0);
                        end
                        if (upd_c) flag_c <= alu_c;
                        PC <= pc_nxt;
                    end
                end
                MEM: if (mem_ack) begin
                    mem_req <= 1'b0;
                    PC      <= pc_inc;
                    if (ir.op == OP_LD) begin
                        regs[ir.rd] <= mem_rdata;
                        flag_z      <= (mem_rdata == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_s_interp_param.sv
// Directed bench for s_interp_param: architectural model checked at every done,
// plus literal expectations for the listed scenarios.
module tb_s_interp_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inst = '0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [7:0]  PC;
    logic        flag_z, flag_c;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [1:0]  dbg_sel = '0;
    logic [15:0] dbg_data;

    s_interp_param #(.DATA_W(16), .ADDR_W(8), .NREG(4)) dut (
        .clk(clk), .rst(rst), .inst(inst), .start(start), .busy(busy), .done(done),
        .err(err), .PC(PC), .flag_z(flag_z), .flag_c(flag_c), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_reg [4];
    logic [7:0]  m_pc;
    logic        m_z, m_c, m_err;
    int          last_lat;
    logic        last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_pc = '0; m_z = 1'b0; m_c = 1'b0; m_err = 1'b0;
    endtask

    // Architectural effect of one instruction, from the opcode table.
    task automatic model_exec(input logic [15:0] in, input logic [15:0] ld_val);
        int unsigned a, b, r;
        bit          wr;
        int          rd, rs;
        logic [7:0]  imm;
        rd = int'(in[11:10]); rs = int'(in[9:8]); imm = in[7:0];
        a = m_reg[rd]; b = m_reg[rs]; r = 0; wr = 1; m_err = 1'b0;
        m_pc = m_pc + 8'd1;
        case (in[15:12])
            4'h0: r = imm;
            4'h1: r = ld_val;
            4'h2: begin r = a + 1; m_c = (r > 65535); end
            4'h4: begin r = a + b; m_c = (r > 65535); end
            4'h5: begin m_c = (a < b); r = a + 65536 - b; end
            4'h6: begin r = a | b; m_c = 1'b0; end
            4'h7: begin r = a & b; m_c = 1'b0; end
            4'h8: begin r = a ^ b; m_c = 1'b0; end
            4'h9: begin m_c = (a < 1); r = a + 65536 - 1; end
            4'hA: begin wr = 0; m_pc = imm; end
            4'hB: begin wr = 0; if (m_z) m_pc = imm; end
            4'hC: begin wr = 0; if (m_c) m_pc = imm; end
            4'hD: r = b;
            4'hF: begin wr = 0; m_err = 1'b1; end
            default: wr = 0;
        endcase
        if (wr) begin
            m_reg[rd] = r[15:0];
            m_z = (r[15:0] == 16'h0);
        end
    endtask

    // Compare process: whenever done is up, the whole visible state must match the model.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_single_cycle", {31'b0, prev_done}, 32'h0);
            chk("pc", {24'b0, PC}, {24'b0, m_pc});
            chk("flag_z", {31'b0, flag_z}, {31'b0, m_z});
            chk("flag_c", {31'b0, flag_c}, {31'b0, m_c});
            chk("err", {31'b0, err}, {31'b0, m_err});
            chk("reg_rd", {16'b0, dbg_data}, {16'b0, m_reg[dbg_sel]});
            chk("busy_at_done", {31'b0, busy}, 32'h1);
        end
        prev_done <= done;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Issue one instruction and follow it to done; drives the memory side if needed.
    task automatic run(input logic [15:0] in, input int dly, input logic [15:0] rdata,
                       input bit extra_start);
        bit          is_mem;
        int          cnt;
        logic [15:0] st_data;
        is_mem  = (in[15:12] == 4'h1) || (in[15:12] == 4'h3);
        st_data = m_reg[int'(in[11:10])];
        @(negedge clk);
        dbg_sel = in[11:10];
        model_exec(in, rdata);
        inst  = in;
        start = 1'b1;
        cnt   = 0;
        forever begin
            @(negedge clk);
            cnt++;
            mem_ack = 1'b0;
            if (cnt == 1 && !extra_start) start = 1'b0;
            if (done) break;
            if (cnt > 60) begin
                chk("done_timeout", 32'(cnt), 32'(is_mem ? 2 + dly : 2));
                start = 1'b0;
                return;
            end
            if (is_mem && cnt >= 2 && cnt <= 1 + dly) begin
                chk("mem_req_held", {31'b0, mem_req}, 32'h1);
                chk("mem_we", {31'b0, mem_we}, {31'b0, in[15:12] == 4'h3});
                chk("mem_addr", {24'b0, mem_addr}, {24'b0, in[7:0]});
                if (in[15:12] == 4'h3) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, st_data});
                if (cnt == 1 + dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
        end
        last_lat = cnt;
        last_err = err;
        chk("latency", 32'(cnt), 32'(is_mem ? 2 + dly : 2));
        if (is_mem) chk("mem_req_cleared", {31'b0, mem_req}, 32'h0);
        if (extra_start) begin
            @(negedge clk);
            chk("busy_after_extra_start", {31'b0, busy}, 32'h0);
            start = 1'b0;
            @(negedge clk);
            chk("no_second_instr", {31'b0, busy}, 32'h0);
        end
    endtask

    initial begin
        model_reset();
        apply_reset();
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done_err", {30'b0, done, err}, 32'h0);
        chk("rst_pc", {24'b0, PC}, 32'h0);
        chk("rst_flags", {30'b0, flag_z, flag_c}, 32'h0);
        chk("rst_mem", {mem_req, mem_we, 6'b0, mem_addr, mem_wdata}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1 chk("rst_reg", {16'b0, dbg_data}, 32'h0);
        end

        run(16'h0401, 0, 16'h0, 1'b0);            // LDI R1,#1
        chk("ldi_latency", 32'(last_lat), 32'd2);
        chk("ldi_r1", {16'b0, dbg_data}, 32'h0001);
        chk("ldi_z_pc", {flag_z, 23'b0, PC}, 32'h0000_0001);

        run(16'h0000, 0, 16'h0, 1'b0);            // LDI R0,#0
        run(16'h9000, 0, 16'h0, 1'b0);            // DEC R0 -> FFFF, borrow
        chk("dec_r0", {15'b0, flag_c, dbg_data}, 32'h0001_FFFF);
        run(16'h4100, 0, 16'h0, 1'b0);            // ADD R0,R1
        chk("add_wrap", {14'b0, flag_z, flag_c, dbg_data}, 32'h0003_0000);
        run(16'h5100, 0, 16'h0, 1'b0);            // SUB R0,R1
        chk("sub_borrow", {14'b0, flag_z, flag_c, dbg_data}, 32'h0001_FFFF);

        run(16'h1810, 3, 16'hBEEF, 1'b0);         // LD R2,[0x10], ack after 3 cycles
        chk("ld_r2", {16'b0, dbg_data}, 32'h0000_BEEF);
        chk("ld_latency", 32'(last_lat), 32'd5);

        run(16'h3820, 1, 16'h0, 1'b1);            // ST R2,[0x20] with a stray start
        chk("st_pc_once", {24'b0, PC}, 32'h07);

        run(16'h8F00, 0, 16'h0, 1'b0);            // XOR R3,R3 -> Z=1 C=0
        run(16'hB040, 0, 16'h0, 1'b0);            // JZ 0x40 taken
        chk("jz_taken", {24'b0, PC}, 32'h40);
        run(16'hC080, 0, 16'h0, 1'b0);            // JC 0x80 not taken
        chk("jc_not_taken", {24'b0, PC}, 32'h41);
        run(16'hDE00, 0, 16'h0, 1'b0);            // MOV R3,R2
        run(16'h7900, 0, 16'h0, 1'b0);            // AND R2,R1
        chk("and_r2", {16'b0, dbg_data}, 32'h0001);
        run(16'h2400, 0, 16'h0, 1'b0);            // INC R1
        run(16'h6D00, 0, 16'h0, 1'b0);            // OR R3,R1
        run(16'hA0FF, 0, 16'h0, 1'b0);            // JMP 0xFF
        run(16'hE000, 0, 16'h0, 1'b0);            // NOP wraps PC
        chk("pc_wrap", {24'b0, PC}, 32'h00);

        run(16'hF000, 0, 16'h0, 1'b0);            // illegal
        chk("ill_err", {31'b0, last_err}, 32'h1);
        chk("ill_state", {14'b0, flag_z, flag_c, 8'b0, PC}, 32'h0000_0001);

        // reset while a load is outstanding
        @(negedge clk);
        dbg_sel = 2'd2;
        inst = 16'h1810; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("rstmem_req_up", {31'b0, mem_req}, 32'h1);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rstmem_cleared", {29'b0, mem_req, busy, 1'b0} | {24'b0, PC}, 32'h0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1234;
        @(negedge clk); mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored", {30'b0, busy, done}, 32'h0);
        chk("late_ack_reg", {16'b0, dbg_data}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
